// File: rtl/booth_radix4_seq_multiplier_if.sv
// Start/ready/valid bundle between the ALU MUL path and the
// radix-4 Booth sequential multiplier.
interface booth_radix4_seq_multiplier_if #(
  parameter int N = 32
);
  localparam int D = N / 2;

  logic         iStart;
  logic [N-1:0] iMultiplicand;
  logic [D-1:0] iSign;
  logic [D-1:0] iMagHi;
  logic [D-1:0] iMagLo;
  logic         oReady;
  logic         oBusy;
  logic         oValid;
  logic [N-1:0] oHI;
  logic [N-1:0] oLO;

  modport master (
    output iStart,
    output iMultiplicand,
    output iSign,
    output iMagHi,
    output iMagLo,
    input  oReady,
    input  oBusy,
    input  oValid,
    input  oHI,
    input  oLO
  );

  modport slave (
    input  iStart,
    input  iMultiplicand,
    input  iSign,
    input  iMagHi,
    input  iMagLo,
    output oReady,
    output oBusy,
    output oValid,
    output oHI,
    output oLO
  );
endinterface

// File: rtl/booth_radix4_seq_multiplier.sv
// Signed N x N sequential multiplier: one pre-encoded radix-4
// Booth digit accumulated per clock, product returned as HI/LO.
module booth_radix4_seq_multiplier #(
  parameter int N = 32
) (
  input logic                          iClk,
  input logic                          nRst,
  booth_radix4_seq_multiplier_if.slave bus
);
  localparam int D  = N / 2;
  localparam int W  = 2 * N;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    mshift_q, mshift_d;
  logic [D-1:0]    sign_q, sign_d;
  logic [D-1:0]    maghi_q, maghi_d;
  logic [D-1:0]    maglo_q, maglo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;

  logic [W-1:0]    mag;
  logic [W-1:0]    term;
  logic [W-1:0]    sum;

  // Digit 0 always sits in bit 0; mshift_q already carries the 4^j weight.
  always_comb begin
    mag = '0;
    priority case (1'b1)
      maghi_q[0]: mag = mshift_q << 1;
      maglo_q[0]: mag = mshift_q;
      default:    mag = '0;
    endcase
    term = sign_q[0] ? (~mag + W'(1)) : mag;
    sum  = acc_q + term;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mshift_d = mshift_q;
    sign_d   = sign_q;
    maghi_d  = maghi_q;
    maglo_d  = maglo_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.iStart) begin
          state_d  = S_BUSY;
          acc_d    = '0;
          cnt_d    = '0;
          mshift_d = {{N{bus.iMultiplicand[N-1]}},
                      bus.iMultiplicand};
          sign_d   = bus.iSign;
          maghi_d  = bus.iMagHi;
          maglo_d  = bus.iMagLo;
        end
      end
      S_BUSY: begin
        acc_d    = sum;
        mshift_d = mshift_q << 2;
        sign_d   = {1'b0, sign_q[D-1:1]};
        maghi_d  = {1'b0, maghi_q[D-1:1]};
        maglo_d  = {1'b0, maglo_q[D-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(D - 1)) begin
          state_d = S_DONE;
          hi_d    = sum[W-1:N];
          lo_d    = sum[N-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mshift_q <= '0;
      sign_q   <= '0;
      maghi_q  <= '0;
      maglo_q  <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mshift_q <= mshift_d;
      sign_q   <= sign_d;
      maghi_q  <= maghi_d;
      maglo_q  <= maglo_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.oReady = (state_q != S_BUSY);
  assign bus.oBusy  = (state_q == S_BUSY);
  assign bus.oValid = (state_q == S_DONE);
  assign bus.oHI    = hi_q;
  assign bus.oLO    = lo_q;
endmodule

// File: tb/tb_booth_radix4_seq_multiplier.sv
// Scoreboard bench: Booth-encodes A, drives digits, compares
// {oHI,oLO} with the exact 64-bit signed product.
module tb_booth_radix4_seq_multiplier;
  localparam int N = 32;
  localparam int D = N / 2;

  logic iClk = 1'b0;
  logic nRst = 1'b0;
  always #5 iClk = ~iClk;

  booth_radix4_seq_multiplier_if #(.N(N)) bus ();

  booth_radix4_seq_multiplier #(.N(N)) dut (
    .iClk (iClk),
    .nRst (nRst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [2*N-1:0] sb[$];

  function automatic void booth(input logic [N-1:0] a,
                                output logic [D-1:0] s,
                                output logic [D-1:0] h,
                                output logic [D-1:0] l);
    logic [2:0] t;
    for (int j = 0; j < D; j++) begin
      t[2] = a[2*j+1];
      t[1] = a[2*j];
      t[0] = (j == 0) ? 1'b0 : a[2*j-1];
      s[j] = t[2];
      h[j] = (t == 3'b011) || (t == 3'b100);
      l[j] = (t == 3'b001) || (t == 3'b010) ||
             (t == 3'b101) || (t == 3'b110);
    end
  endfunction

  task automatic drive_ops(input logic [N-1:0] a, input logic [N-1:0] m);
    logic [D-1:0] s, h, l;
    booth(a, s, h, l);
    bus.iMultiplicand = m;
    bus.iSign = s;
    bus.iMagHi = h;
    bus.iMagLo = l;
  endtask

  // Called just after a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] m);
    logic signed [2*N-1:0] p;
    p = $signed({{N{a[N-1]}}, a}) * $signed({{N{m[N-1]}}, m});
    drive_ops(a, m);
    bus.iStart = 1'b1;
    sb.push_back(p);
    @(negedge iClk);
    bus.iStart = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_lat,
                           output int busy);
    int k;
    logic [2*N-1:0] exp;
    k = 0;
    busy = 0;
    while (bus.oValid !== 1'b1 && k < 40) begin
      if (bus.oBusy === 1'b1) busy++;
      n_cmp++;
      if (bus.oReady === bus.oBusy) begin
        n_err++;
        $display("FAIL %s ready_busy: ready=%b busy=%b must differ",
                 name, bus.oReady, bus.oBusy);
      end
      @(negedge iClk);
      k++;
    end
    n_cmp++;
    if (k !== exp_lat) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles expected %0d",
               name, k, exp_lat);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s scoreboard: empty queue", name);
    end else begin
      exp = sb.pop_front();
      if ({bus.oHI, bus.oLO} !== exp) begin
        n_err++;
        $display("FAIL %s product: got %h expected %h",
                 name, {bus.oHI, bus.oLO}, exp);
      end
    end
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (2) @(negedge iClk);
    n_cmp++;
    if ({bus.oReady, bus.oBusy, bus.oValid} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_flags: got rdy/busy/vld=%b expected 100",
               {bus.oReady, bus.oBusy, bus.oValid});
    end
    n_cmp++;
    if ({bus.oHI, bus.oLO} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_product: got %h expected 0",
               {bus.oHI, bus.oLO});
    end
    nRst = 1'b1;
    @(negedge iClk);
  endtask

  task automatic test_basic();
    int busy;
    start_op(32'd3, 32'd5);
    wait_done("t1_3x5", 16, busy);
    n_cmp++;
    if (busy !== 16) begin
      n_err++;
      $display("FAIL t1_busy_cycles: got %0d expected 16", busy);
    end
    start_op(32'hFFFFFFFF, 32'h7FFFFFFF);
    wait_done("t2_neg1xmax", 16, busy);
    start_op(32'h80000000, 32'h80000000);
    wait_done("t3_minxmin", 16, busy);
    start_op(32'd0, -32'sd7);
    wait_done("t3_0xneg7", 16, busy);
  endtask

  task automatic test_ignored_start();
    int busy;
    start_op(32'd2, 32'd3);
    repeat (4) @(negedge iClk);
    drive_ops(32'd9, 32'd100);
    bus.iStart = 1'b1;
    @(negedge iClk);
    bus.iStart = 1'b0;
    wait_done("t4_ignored", 11, busy);
  endtask

  task automatic test_back_to_back();
    int busy;
    start_op(32'd4, 32'd4);
    n_cmp++;
    if (bus.oValid !== 1'b0) begin
      n_err++;
      $display("FAIL t4_valid_drop: got %b expected 0", bus.oValid);
    end
    n_cmp++;
    if ({bus.oHI, bus.oLO} !== 64'd6) begin
      n_err++;
      $display("FAIL t4_hold_busy: got %h expected 6",
               {bus.oHI, bus.oLO});
    end
    wait_done("t4_b2b", 16, busy);
  endtask

  task automatic test_reset_mid_busy();
    int busy;
    start_op(32'd12345, -32'sd678);
    repeat (6) @(negedge iClk);
    nRst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.oReady, bus.oBusy, bus.oValid} !== 3'b100) begin
      n_err++;
      $display("FAIL t5_flags: got rdy/busy/vld=%b expected 100",
               {bus.oReady, bus.oBusy, bus.oValid});
    end
    n_cmp++;
    if ({bus.oHI, bus.oLO} !== 64'h0) begin
      n_err++;
      $display("FAIL t5_product: got %h expected 0",
               {bus.oHI, bus.oLO});
    end
    sb.delete();
    @(negedge iClk);
    nRst = 1'b1;
    repeat (2) @(negedge iClk);
    n_cmp++;
    if ({bus.oReady, bus.oValid} !== 2'b10) begin
      n_err++;
      $display("FAIL t5_idle: got rdy/vld=%b expected 10",
               {bus.oReady, bus.oValid});
    end
    start_op(32'd12345, -32'sd678);
    wait_done("t5_restart", 16, busy);
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] c[4];
    c[0] = 32'h80000000;
    c[1] = 32'h7FFFFFFF;
    c[2] = 32'h0;
    c[3] = 32'hFFFFFFFF;
    if ($urandom_range(0, 7) == 0) return c[$urandom_range(0, 3)];
    return $urandom();
  endfunction

  task automatic test_random();
    int busy;
    logic [2*N-1:0] held;
    for (int i = 0; i < 1500; i++) begin
      start_op(pick(), pick());
      wait_done("t6_random", 16, busy);
      if ($urandom_range(0, 1) == 1) begin
        held = {bus.oHI, bus.oLO};
        repeat ($urandom_range(1, 3)) begin
          @(negedge iClk);
          n_cmp++;
          if (bus.oValid !== 1'b1 || {bus.oHI, bus.oLO} !== held) begin
            n_err++;
            $display("FAIL t6_done_hold: vld=%b prod=%h expected 1 %h",
                     bus.oValid, {bus.oHI, bus.oLO}, held);
          end
        end
      end
    end
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iMultiplicand = '0;
    bus.iSign = '0;
    bus.iMagHi = '0;
    bus.iMagLo = '0;
    test_reset();
    test_basic();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
